// File: rtl/dmem_resp_model.sv
// Data-memory target for the core mem_d_* port: tagged, in-order responses
// after a fixed latency, with strobe writes, outstanding limit and stalls.
module dmem_resp_model #(
  parameter logic [31:0] ADDR_BASE       = 32'h80000000,
  parameter int          DEPTH_WORDS     = 256,
  parameter int          RESP_LATENCY    = 2,
  parameter int          MAX_OUTSTANDING = 4,
  parameter int          TAG_W           = 11,
  parameter int          STALL_EVERY     = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [31:0]      mem_d_addr_i,
  input  logic [31:0]      mem_d_data_wr_i,
  input  logic             mem_d_rd_i,
  input  logic [3:0]       mem_d_wr_i,
  input  logic             mem_d_cacheable_i,
  input  logic [TAG_W-1:0] mem_d_req_tag_i,
  input  logic             mem_d_invalidate_i,
  input  logic             mem_d_writeback_i,
  input  logic             mem_d_flush_i,
  output logic             mem_d_accept_o,
  output logic             mem_d_ack_o,
  output logic             mem_d_error_o,
  output logic [TAG_W-1:0] mem_d_resp_tag_o,
  output logic [31:0]      mem_d_data_rd_o,
  output logic [15:0]      err_count_o
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int LAST  = RESP_LATENCY - 1;
  localparam logic [32:0] ADDR_END =
    {1'b0, ADDR_BASE} + 33'(4 * DEPTH_WORDS);

  typedef enum logic {ST_OPEN, ST_STALL} st_e;

  logic [31:0]      mem_q [DEPTH_WORDS];
  logic             pv_q [RESP_LATENCY];
  logic             pv_d [RESP_LATENCY];
  logic             pe_q [RESP_LATENCY];
  logic             pe_d [RESP_LATENCY];
  logic [TAG_W-1:0] ptag_q [RESP_LATENCY];
  logic [TAG_W-1:0] ptag_d [RESP_LATENCY];
  logic [31:0]      pdat_q [RESP_LATENCY];
  logic [31:0]      pdat_d [RESP_LATENCY];

  logic [4:0]  outst_q, outst_d;
  logic [15:0] scnt_q, scnt_d;
  st_e         st_q, st_d;
  logic [15:0] err_cnt_q, err_cnt_d;
  logic [15:0] cach_cnt_q, cach_cnt_d;

  logic             maint, wr_any, req, xfer;
  logic             hit, bad, we, ack;
  logic [31:0]      off, rdata, wdata;
  logic [IDX_W-1:0] idx;
  logic             unused_bits;

  assign maint  = mem_d_invalidate_i | mem_d_writeback_i | mem_d_flush_i;
  assign wr_any = |mem_d_wr_i;
  assign req    = mem_d_rd_i | wr_any | maint;

  assign mem_d_accept_o = ~rst_i
    & (outst_q < 5'(MAX_OUTSTANDING))
    & (st_q == ST_OPEN);
  assign xfer = req & mem_d_accept_o;

  assign off = mem_d_addr_i - ADDR_BASE;
  assign idx = off[IDX_W+1:2];
  assign hit = ({1'b0, mem_d_addr_i} >= {1'b0, ADDR_BASE})
    && ({1'b0, mem_d_addr_i} < ADDR_END);

  // maintenance ops never fail, even off-window or with rd/wr set
  assign bad = ~maint & (~hit | (mem_d_rd_i & wr_any));
  assign we  = xfer & ~maint & ~bad & wr_any;

  assign rdata = mem_q[idx];
  assign ack   = pv_q[LAST];

  always_comb begin
    wdata = rdata;
    for (int i = 0; i < 4; i++) begin
      if (mem_d_wr_i[i]) wdata[8*i +: 8] = mem_d_data_wr_i[8*i +: 8];
    end
  end

  always_comb begin
    pv_d[0]   = xfer;
    pe_d[0]   = xfer & bad;
    ptag_d[0] = xfer ? mem_d_req_tag_i : '0;
    pdat_d[0] = (xfer & mem_d_rd_i & ~bad & ~maint) ? rdata : 32'd0;
    for (int i = 1; i < RESP_LATENCY; i++) begin
      pv_d[i]   = pv_q[i-1];
      pe_d[i]   = pe_q[i-1];
      ptag_d[i] = ptag_q[i-1];
      pdat_d[i] = pdat_q[i-1];
    end
  end

  always_comb begin
    outst_d    = outst_q + 5'(xfer) - 5'(ack);
    cach_cnt_d = cach_cnt_q + 16'(xfer & mem_d_cacheable_i);
    err_cnt_d  = err_cnt_q;
    if (ack && pe_q[LAST] && err_cnt_q != 16'hFFFF)
      err_cnt_d = err_cnt_q + 16'd1;
  end

  always_comb begin
    st_d   = st_q;
    scnt_d = scnt_q;
    unique case (st_q)
      ST_OPEN: begin
        if (xfer && STALL_EVERY != 0) begin
          if (scnt_q + 16'd1 == 16'(STALL_EVERY)) begin
            st_d   = ST_STALL;
            scnt_d = '0;
          end else begin
            scnt_d = scnt_q + 16'd1;
          end
        end
      end
      ST_STALL: st_d = ST_OPEN;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < RESP_LATENCY; i++) begin
        pv_q[i]   <= 1'b0;
        pe_q[i]   <= 1'b0;
        ptag_q[i] <= '0;
        pdat_q[i] <= '0;
      end
      outst_q    <= '0;
      scnt_q     <= '0;
      st_q       <= ST_OPEN;
      err_cnt_q  <= '0;
      cach_cnt_q <= '0;
    end else begin
      for (int i = 0; i < RESP_LATENCY; i++) begin
        pv_q[i]   <= pv_d[i];
        pe_q[i]   <= pe_d[i];
        ptag_q[i] <= ptag_d[i];
        pdat_q[i] <= pdat_d[i];
      end
      outst_q    <= outst_d;
      scnt_q     <= scnt_d;
      st_q       <= st_d;
      err_cnt_q  <= err_cnt_d;
      cach_cnt_q <= cach_cnt_d;
    end
  end

  // array has no reset so contents survive rst_i
  always_ff @(posedge clk_i) begin
    if (we) mem_q[idx] <= wdata;
  end

  assign mem_d_ack_o      = ack;
  assign mem_d_error_o    = pe_q[LAST];
  assign mem_d_resp_tag_o = ptag_q[LAST];
  assign mem_d_data_rd_o  = pdat_q[LAST];
  assign err_count_o      = err_cnt_q;

  assign unused_bits = ^{cach_cnt_q, off[31:IDX_W+2], off[1:0]};

endmodule

// File: tb/tb_dmem_resp_model.sv
// Scoreboard bench for dmem_resp_model: three instances cover the
// default latency, the deep-latency outstanding limit and the stall FSM.
module tb_dmem_resp_model;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst  [3];
  logic [31:0] addr [3];
  logic [31:0] wdat [3];
  logic        rd   [3];
  logic [3:0]  wr   [3];
  logic        cach [3];
  logic [10:0] tag  [3];
  logic        inv  [3];
  logic        wb   [3];
  logic        fl   [3];
  logic        acc  [3];
  logic        ack  [3];
  logic        err  [3];
  logic [10:0] rtag [3];
  logic [31:0] rdat [3];
  logic [15:0] ecnt [3];

  dmem_resp_model #(.RESP_LATENCY(2), .MAX_OUTSTANDING(4)) u_a (
    .clk_i(clk), .rst_i(rst[0]),
    .mem_d_addr_i(addr[0]), .mem_d_data_wr_i(wdat[0]),
    .mem_d_rd_i(rd[0]), .mem_d_wr_i(wr[0]),
    .mem_d_cacheable_i(cach[0]), .mem_d_req_tag_i(tag[0]),
    .mem_d_invalidate_i(inv[0]), .mem_d_writeback_i(wb[0]),
    .mem_d_flush_i(fl[0]), .mem_d_accept_o(acc[0]),
    .mem_d_ack_o(ack[0]), .mem_d_error_o(err[0]),
    .mem_d_resp_tag_o(rtag[0]), .mem_d_data_rd_o(rdat[0]),
    .err_count_o(ecnt[0]));

  dmem_resp_model #(.RESP_LATENCY(8), .MAX_OUTSTANDING(4)) u_b (
    .clk_i(clk), .rst_i(rst[1]),
    .mem_d_addr_i(addr[1]), .mem_d_data_wr_i(wdat[1]),
    .mem_d_rd_i(rd[1]), .mem_d_wr_i(wr[1]),
    .mem_d_cacheable_i(cach[1]), .mem_d_req_tag_i(tag[1]),
    .mem_d_invalidate_i(inv[1]), .mem_d_writeback_i(wb[1]),
    .mem_d_flush_i(fl[1]), .mem_d_accept_o(acc[1]),
    .mem_d_ack_o(ack[1]), .mem_d_error_o(err[1]),
    .mem_d_resp_tag_o(rtag[1]), .mem_d_data_rd_o(rdat[1]),
    .err_count_o(ecnt[1]));

  dmem_resp_model #(.RESP_LATENCY(2), .MAX_OUTSTANDING(16),
                    .STALL_EVERY(3)) u_c (
    .clk_i(clk), .rst_i(rst[2]),
    .mem_d_addr_i(addr[2]), .mem_d_data_wr_i(wdat[2]),
    .mem_d_rd_i(rd[2]), .mem_d_wr_i(wr[2]),
    .mem_d_cacheable_i(cach[2]), .mem_d_req_tag_i(tag[2]),
    .mem_d_invalidate_i(inv[2]), .mem_d_writeback_i(wb[2]),
    .mem_d_flush_i(fl[2]), .mem_d_accept_o(acc[2]),
    .mem_d_ack_o(ack[2]), .mem_d_error_o(err[2]),
    .mem_d_resp_tag_o(rtag[2]), .mem_d_data_rd_o(rdat[2]),
    .err_count_o(ecnt[2]));

  typedef struct {
    logic [10:0] tag;
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  logic mon_on = 1'b0;
  logic [9:0] pat = 10'b1110111011;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic pop_chk(input int k);
    exp_t e;
    int   sz;
    sz = (k == 0) ? qa.size() : qb.size();
    if (sz == 0) begin
      chk(k == 0 ? "a_spurious_ack" : "b_spurious_ack", 32'd1, 32'd0);
    end else begin
      e = (k == 0) ? qa.pop_front() : qb.pop_front();
      chk("resp_tag", 32'(rtag[k]), 32'(e.tag));
      chk("resp_data", rdat[k], e.data);
      chk("resp_err", 32'(err[k]), 32'(e.err));
      chk("resp_cyc", cyc, e.cyc);
    end
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      for (int k = 0; k < 2; k++) begin
        if (ack[k]) pop_chk(k);
        else chk("idle_zero", rdat[k] | 32'(rtag[k]) | 32'(err[k]), 32'd0);
      end
    end
  end

  task automatic issue(input int k, input logic r, input logic [3:0] w,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [10:0] t, input logic [2:0] m,
                       input logic ee, input logic [31:0] ed);
    exp_t e;
    int   n;
    n = 0;
    rd[k] = r; wr[k] = w; addr[k] = a; wdat[k] = d; tag[k] = t;
    inv[k] = m[2]; wb[k] = m[1]; fl[k] = m[0];
    while (!acc[k] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!acc[k]) begin
      chk("accept_timeout", 32'(acc[k]), 32'd1);
    end else begin
      e.tag = t; e.data = ed; e.err = ee;
      e.cyc = cyc + ((k == 1) ? 8 : 2);
      if (k == 0) qa.push_back(e);
      else qb.push_back(e);
    end
    @(negedge clk);
    rd[k] = 1'b0; wr[k] = 4'h0; inv[k] = 1'b0; wb[k] = 1'b0; fl[k] = 1'b0;
  endtask

  task automatic drain(input int k);
    int n;
    n = 0;
    while (((k == 0) ? qa.size() : qb.size()) > 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("drain", (k == 0) ? qa.size() : qb.size(), 0);
  endtask

  initial begin
    int n;
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1; addr[k] = '0; wdat[k] = '0; rd[k] = 1'b0;
      wr[k] = 4'h0; cach[k] = 1'b0; tag[k] = '0;
      inv[k] = 1'b0; wb[k] = 1'b0; fl[k] = 1'b0;
    end
    repeat (3) @(negedge clk);
    chk("rst_acc", 32'(acc[0]), 0);
    chk("rst_ack", 32'(ack[0]), 0);
    chk("rst_ecnt", 32'(ecnt[0]), 0);
    chk("rst_data", rdat[0] | 32'(rtag[0]), 0);
    for (int k = 0; k < 3; k++) rst[k] = 1'b0;
    #1;
    chk("rel_acc", 32'(acc[0]), 1);
    mon_on = 1'b1;

    cach[0] = 1'b1;
    issue(0, 0, 4'hF, 32'h80000004, 32'hA5A5A5A5, 5, 0, 0, 0);
    issue(0, 1, 4'h0, 32'h80000004, 0, 6, 0, 0, 32'hA5A5A5A5);
    issue(0, 0, 4'b0010, 32'h80000004, 32'h00003C00, 7, 0, 0, 0);
    issue(0, 1, 4'h0, 32'h80000004, 0, 8, 0, 0, 32'hA5A53CA5);
    cach[0] = 1'b0;
    issue(0, 0, 4'hF, 32'h800003FC, 32'h12345678, 12, 0, 0, 0);
    issue(0, 0, 4'hF, 32'h80000000, 32'h0BADF00D, 13, 0, 0, 0);
    issue(0, 1, 4'h0, 32'h800003FC, 0, 18, 0, 0, 32'h12345678);
    issue(0, 1, 4'h0, 32'h80000000, 0, 19, 0, 0, 32'h0BADF00D);

    issue(0, 1, 4'h0, 32'h70000000, 0, 9, 0, 1, 0);
    issue(0, 1, 4'h0, 32'h80000400, 0, 10, 0, 1, 0);
    drain(0);
    chk("ecnt_two", 32'(ecnt[0]), 2);
    issue(0, 1, 4'h0, 32'h80000004, 0, 11, 0, 0, 32'hA5A53CA5);
    issue(0, 0, 4'hF, 32'h80000400, 32'hFFFFFFFF, 14, 0, 1, 0);
    issue(0, 0, 4'hF, 32'h7FFFFFFC, 32'hFFFFFFFF, 17, 0, 1, 0);
    issue(0, 1, 4'hF, 32'h80000004, 32'h0, 15, 0, 1, 0);
    issue(0, 1, 4'h0, 32'h80000000, 0, 20, 0, 0, 32'h0BADF00D);
    issue(0, 1, 4'h0, 32'h800003FC, 0, 21, 0, 0, 32'h12345678);
    issue(0, 1, 4'h0, 32'h80000004, 0, 22, 0, 0, 32'hA5A53CA5);
    issue(0, 1, 4'hF, 32'h70000000, 0, 16, 3'b100, 0, 0);
    issue(0, 0, 4'h0, 32'h80000004, 0, 23, 3'b010, 0, 0);
    issue(0, 0, 4'h0, 32'h80000004, 0, 24, 3'b001, 0, 0);
    drain(0);
    chk("ecnt_five", 32'(ecnt[0]), 5);

    issue(0, 1, 4'h0, 32'h80000000, 0, 25, 0, 0, 32'h0BADF00D);
    issue(0, 1, 4'h0, 32'h80000004, 0, 26, 0, 0, 32'hA5A53CA5);
    rst[0] = 1'b1;
    #1;
    chk("a_rst_acc", 32'(acc[0]), 0);
    qa.delete();
    @(negedge clk);
    rst[0] = 1'b0;
    #1;
    chk("a_rel_acc", 32'(acc[0]), 1);
    chk("a_rel_ecnt", 32'(ecnt[0]), 0);
    repeat (4) @(negedge clk);
    issue(0, 1, 4'h0, 32'h80000004, 0, 27, 0, 0, 32'hA5A53CA5);
    drain(0);

    issue(1, 0, 4'hF, 32'h80000000, 32'hCAFEBABE, 1, 0, 0, 0);
    drain(1);
    for (int i = 0; i < 4; i++)
      issue(1, 1, 4'h0, 32'h80000000, 0, 11'(40 + i), 0, 0, 32'hCAFEBABE);
    chk("b_full_acc", 32'(acc[1]), 0);
    n = 0;
    while (!ack[1] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("b_first_ack", 32'(ack[1]), 1);
    chk("b_acc_at_ack", 32'(acc[1]), 0);
    @(negedge clk);
    chk("b_acc_after_ack", 32'(acc[1]), 1);
    issue(1, 1, 4'h0, 32'h80000000, 0, 44, 0, 0, 32'hCAFEBABE);
    issue(1, 1, 4'h0, 32'h80000000, 0, 45, 0, 0, 32'hCAFEBABE);
    drain(1);

    for (int i = 0; i < 3; i++)
      issue(1, 1, 4'h0, 32'h80000000, 0, 11'(50 + i), 0, 0, 32'hCAFEBABE);
    rst[1] = 1'b1;
    #1;
    chk("b_rst_acc", 32'(acc[1]), 0);
    qb.delete();
    @(negedge clk);
    rst[1] = 1'b0;
    #1;
    chk("b_rel_acc", 32'(acc[1]), 1);
    chk("b_outst", 32'(u_b.outst_q), 0);
    repeat (12) @(negedge clk);
    issue(1, 1, 4'h0, 32'h80000000, 0, 60, 0, 0, 32'hCAFEBABE);
    drain(1);

    rd[2] = 1'b1;
    addr[2] = 32'h80000000;
    for (int i = 0; i < 10; i++) begin
      chk("c_stall_pat", 32'(acc[2]), 32'(pat[9-i]));
      @(negedge clk);
    end
    rd[2] = 1'b0;
    repeat (4) @(negedge clk);

    chk("qa_left", qa.size(), 0);
    chk("qb_left", qb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
